zbb_bitcount_seq: RTL and testbench
===================================

// Module: zbb_bitcount_seq
// PURPOSE
//  Multi-cycle bit-count execution unit for Zbb CLZ/CTZ/CPOP. Sits beside the
//  single-cycle Zbb unit: it takes rs1 from decode and returns a result plus the
//  destination register index to the writeback mux. The core stalls on busy.
//  Scans STEP bits per cycle, trading latency for area.
// PARAMETERS
//  STEP  4  bits scanned per cycle; legal values 1,2,4,8,16,32. K = 32/STEP chunks.
// PORTS
//  clk        in   1   core clock
//  rst_n      in   1   synchronous, active-low reset
//  flush      in   1   abort any operation in flight (pipeline flush)
//  req_valid  in   1   request present
//  req_ready  out  1   unit can accept a request
//  req_op     in   2   00=CLZ 01=CTZ 10=CPOP 11=reserved
//  req_rs1    in   32  operand
//  req_rd     in   5   destination register index
//  rsp_valid  out  1   result available
//  rsp_ready  in   1   writeback consumes result
//  rsp_data   out  32  result, zero-extended count 0..32
//  rsp_rd     out  5   req_rd captured with the request
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  One clock (clk); reset is synchronous and active-low (rst_n).
//  While rst_n=0 at a clk edge: state=IDLE; rsp_valid=0; rsp_data=0; rsp_rd=0;
//   busy=0. Reset mid-operation discards the operation with no response.
//  States:
//   IDLE: req_ready = !flush. Accept on req_valid&&req_ready: capture op, rd
//    and operand (bit-reversed for CTZ, so CTZ reuses the CLZ path).
//    Clear count, found, and chunk counter. Go to RUN.
//   RUN: each cycle, take the top STEP bits of the shift register.
//    CPOP: count += popcount(chunk).
//    CLZ/CTZ: if !found, count += leading zeros of chunk; found |= (chunk!=0).
//    Reserved op: count unchanged (stays 0).
//    Shift left by STEP and increment the chunk counter.
//    After the K-th chunk: rsp_data={26'b0,count}, rsp_valid=1, go to DONE.
//   DONE: hold rsp_data, rsp_rd and rsp_valid until rsp_valid&&rsp_ready,
//    then go to IDLE with rsp_valid=0.
//    req_ready=0 in DONE, so there is no same-cycle re-accept.
//  Latency: accept edge E -> rsp_valid high after edge E+K. Fixed, data-independent.
//   STEP=4 gives rsp_valid 8 cycles after accept.
//   Throughput: one op per K+2 cycles with rsp_ready tied high.
//  Flush: at an edge with flush=1, go to IDLE and set rsp_valid=0.
//   Flush overrides accept, RUN progress and a DONE handshake in the same cycle.
//  Count is 6 bits; the maximum is 32 (operand 0 for CLZ/CTZ, 0xFFFFFFFF for CPOP).
//   No wrap is possible.
//  Output registers change only on state transitions; rsp_* are stable while
//   rsp_valid=1 and rsp_ready=0.
//  Inputs are ignored outside IDLE; req_* need not be held after acceptance.
// TESTING (STEP=4 unless noted)
//  CLZ 0x00010000, rd=5 -> rsp_data=15, rsp_rd=5, rsp_valid exactly 8 cycles after accept.
//  CTZ 0x00010000 -> 16. CTZ 0x00000000 -> 32. CLZ 0x80000000 -> 0.
//  CPOP 0xF0F00001 -> 9. CPOP 0xFFFFFFFF -> 32. Op 11 with 0xFFFFFFFF -> 0.
//  rsp_ready held low 5 cycles in DONE -> rsp_data/rsp_rd stable, req_ready=0.
//   Then 1 cycle after the handshake: req_ready=1, busy=0.
//  flush in RUN cycle 3 -> IDLE next cycle, no rsp_valid ever.
//   flush with req_valid in IDLE -> not accepted.
//  rst_n=0 during RUN -> next cycle busy=0, rsp_valid=0, rsp_data=0.
//   A new CLZ 0x1 then returns 31.
//  Sweep STEP in {1,8,32} with random operands vs reference model.
//   Latency must be 32, 4 and 1 cycles respectively.

Source files
------------

// File: rtl/zbb_bitcount_seq_if.sv
// Request/response bundle between decode/writeback and the multi-cycle
// Zbb bit-count unit (CLZ/CTZ/CPOP).
interface zbb_bitcount_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_rs1;
  logic [4:0]  req_rd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;

  modport master (
    output req_valid, req_op, req_rs1, req_rd, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_rd
  );

  modport slave (
    input  req_valid, req_op, req_rs1, req_rd, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_rd
  );
endinterface

// File: rtl/zbb_bitcount_seq.sv
// Multi-cycle Zbb bit-count unit: CLZ/CTZ/CPOP over a 32-bit operand,
// scanning STEP bits per cycle (K = 32/STEP chunks, fixed latency K).
// CTZ bit-reverses the operand on accept so it shares the CLZ path.
module zbb_bitcount_seq #(
  parameter int STEP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  zbb_bitcount_seq_if.slave bus,
  output logic              busy
);

  localparam int K  = 32 / STEP;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_op;
  logic [31:0]      r_sh;
  logic [4:0]       r_rd;
  logic [5:0]       r_count;
  logic             r_found;
  logic [CW-1:0]    r_chunk;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_data;
  logic [4:0]       r_rsp_rd;

  logic [STEP-1:0]  w_chunk;
  logic [5:0]       w_count_nxt;
  logic             w_found_nxt;
  logic             w_accept;
  logic             w_last;

  function automatic logic [5:0] f_lz(input logic [STEP-1:0] c);
    logic [5:0] n;
    logic       seen;
    n    = '0;
    seen = 1'b0;
    for (int i = STEP - 1; i >= 0; i--) begin
      if (!seen && !c[i]) n = n + 6'd1;
      else                seen = 1'b1;
    end
    return n;
  endfunction

  function automatic logic [5:0] f_pop(input logic [STEP-1:0] c);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < STEP; i++) n = n + {5'b0, c[i]};
    return n;
  endfunction

  function automatic logic [31:0] f_rev(input logic [31:0] x);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = x[31 - i];
    return r;
  endfunction

  assign w_chunk       = r_sh[31 -: STEP];
  assign w_last        = (r_chunk == LAST);
  assign bus.req_ready = (r_state == S_IDLE) && !flush;
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign busy          = (r_state != S_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_rd    = r_rsp_rd;

  // Per-chunk count update; reserved op leaves the count at zero.
  always_comb begin
    w_count_nxt = r_count;
    w_found_nxt = r_found;
    case (r_op)
      2'b10: w_count_nxt = r_count + f_pop(w_chunk);
      2'b00, 2'b01: begin
        if (!r_found) begin
          w_count_nxt = r_count + f_lz(w_chunk);
          w_found_nxt = (w_chunk != '0);
        end
      end
      default: ;
    endcase
  end

  // Next-state logic; flush wins over accept, scan progress and handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)      w_state_nxt = S_RUN;
      S_RUN:   if (w_last)        w_state_nxt = S_DONE;
      S_DONE:  if (bus.rsp_ready) w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Operand capture, chunk scan and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op        <= '0;
      r_sh        <= '0;
      r_rd        <= '0;
      r_count     <= '0;
      r_found     <= 1'b0;
      r_chunk     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_rd    <= '0;
    end else if (flush) begin
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= bus.req_op;
            r_rd    <= bus.req_rd;
            r_sh    <= (bus.req_op == 2'b01) ? f_rev(bus.req_rs1) : bus.req_rs1;
            r_count <= '0;
            r_found <= 1'b0;
            r_chunk <= '0;
          end
        end
        S_RUN: begin
          r_count <= w_count_nxt;
          r_found <= w_found_nxt;
          r_sh    <= r_sh << STEP;
          r_chunk <= r_chunk + CW'(1);
          if (w_last) begin
            r_rsp_data  <= {26'b0, w_count_nxt};
            r_rsp_rd    <= r_rd;
            r_rsp_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_zbb_bitcount_seq.sv
// Scoreboard bench for zbb_bitcount_seq: one STEP=4 unit for directed cases
// plus STEP=1/8/32 units driven together for the sweep.
module tb_zbb_bitcount_seq;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] busy;
  int         cyc   = 0;
  int         total = 0;
  int         bad   = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    int          t;
  } exp_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  zbb_bitcount_seq_if ifc[4] ();

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0d expected %0d", nm, d, act, exp);
    end
  endtask

  // DUT g: g=0 STEP=4 (directed), g=1..3 STEP=1/8/32 (sweep); each has its own monitor.
  for (genvar g = 0; g < 4; g++) begin : gd
    localparam int S = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 8 : 32;
    localparam int K = 32 / S;
    exp_t q[$];
    exp_t cur;
    bit   hc = 1'b0;
    bit   pv = 1'b0;

    zbb_bitcount_seq #(.STEP(S)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush ((g == 0) ? flush : 1'b0),
      .bus   (ifc[g]),
      .busy  (busy[g])
    );

    always @(negedge clk) begin
      if (!rst_n) begin
        pv = 1'b0;
        hc = 1'b0;
      end else begin
        if (ifc[g].rsp_valid && !pv) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            hc = 1'b0;
            $display("FAIL unexpected_rsp dut%0d: got data %0d, expected no response", g, ifc[g].rsp_data);
          end else begin
            cur = q.pop_front();
            hc  = 1'b1;
            chk("rsp_data", g, ifc[g].rsp_data, cur.data);
            chk("rsp_rd", g, {27'b0, ifc[g].rsp_rd}, {27'b0, cur.rd});
            chk("latency", g, 32'(cyc - cur.t), 32'(K));
          end
        end else if (ifc[g].rsp_valid && hc) begin
          chk("hold_data", g, ifc[g].rsp_data, cur.data);
          chk("hold_rd", g, {27'b0, ifc[g].rsp_rd}, {27'b0, cur.rd});
        end
        pv = ifc[g].rsp_valid;
      end
    end
  end

  function automatic logic [5:0] ref_cnt(input logic [1:0] op, input logic [31:0] x);
    case (op)
      2'b00: begin
        for (int i = 31; i >= 0; i--) if (x[i]) return 6'(31 - i);
        return 6'd32;
      end
      2'b01: begin
        for (int i = 0; i < 32; i++) if (x[i]) return 6'(i);
        return 6'd32;
      end
      2'b10:   return 6'($countones(x));
      default: return 6'd0;
    endcase
  endfunction

  task automatic issue0(input logic [1:0] op, input logic [31:0] rs1, input logic [4:0] rd,
                        input logic [5:0] ev, input bit push);
    int n = 0;
    @(negedge clk);
    ifc[0].req_valid = 1'b1;
    ifc[0].req_op    = op;
    ifc[0].req_rs1   = rs1;
    ifc[0].req_rd    = rd;
    #1;
    while (!ifc[0].req_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("ready_at_issue", 0, {31'b0, ifc[0].req_ready}, 32'd1);
    if (push) gd[0].q.push_back('{data: {26'b0, ev}, rd: rd, t: cyc + 1});
    @(negedge clk);
    ifc[0].req_valid = 1'b0;
    ifc[0].req_op    = 2'b11;
    ifc[0].req_rs1   = '1;
    ifc[0].req_rd    = '0;
  endtask

  task automatic issue_sw(input logic [1:0] op, input logic [31:0] rs1, input logic [4:0] rd);
    logic [5:0] ev;
    ev = ref_cnt(op, rs1);
    @(negedge clk);
    ifc[1].req_valid = 1'b1; ifc[1].req_op = op; ifc[1].req_rs1 = rs1; ifc[1].req_rd = rd;
    ifc[2].req_valid = 1'b1; ifc[2].req_op = op; ifc[2].req_rs1 = rs1; ifc[2].req_rd = rd;
    ifc[3].req_valid = 1'b1; ifc[3].req_op = op; ifc[3].req_rs1 = rs1; ifc[3].req_rd = rd;
    #1;
    chk("sweep_ready", 1, {31'b0, ifc[1].req_ready}, 32'd1);
    chk("sweep_ready", 2, {31'b0, ifc[2].req_ready}, 32'd1);
    chk("sweep_ready", 3, {31'b0, ifc[3].req_ready}, 32'd1);
    gd[1].q.push_back('{data: {26'b0, ev}, rd: rd, t: cyc + 1});
    gd[2].q.push_back('{data: {26'b0, ev}, rd: rd, t: cyc + 1});
    gd[3].q.push_back('{data: {26'b0, ev}, rd: rd, t: cyc + 1});
    @(negedge clk);
    ifc[1].req_valid = 1'b0; ifc[1].req_rs1 = '0;
    ifc[2].req_valid = 1'b0; ifc[2].req_rs1 = '0;
    ifc[3].req_valid = 1'b0; ifc[3].req_rs1 = '0;
  endtask

  task automatic wait_all(input int budget);
    int n = 0;
    while (n < budget && !(gd[0].q.size() == 0 && gd[1].q.size() == 0 &&
                           gd[2].q.size() == 0 && gd[3].q.size() == 0 && busy == 4'b0)) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 0, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int n;
    ifc[0].req_valid = 1'b0; ifc[0].req_op = '0; ifc[0].req_rs1 = '0; ifc[0].req_rd = '0; ifc[0].rsp_ready = 1'b1;
    ifc[1].req_valid = 1'b0; ifc[1].req_op = '0; ifc[1].req_rs1 = '0; ifc[1].req_rd = '0; ifc[1].rsp_ready = 1'b1;
    ifc[2].req_valid = 1'b0; ifc[2].req_op = '0; ifc[2].req_rs1 = '0; ifc[2].req_rd = '0; ifc[2].rsp_ready = 1'b1;
    ifc[3].req_valid = 1'b0; ifc[3].req_op = '0; ifc[3].req_rs1 = '0; ifc[3].req_rd = '0; ifc[3].rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 0, {28'b0, busy}, 32'd0);
    chk("rst_rsp_valid", 0, {31'b0, ifc[0].rsp_valid}, 32'd0);
    chk("rst_rsp_data", 0, ifc[0].rsp_data, 32'd0);
    chk("rst_rsp_rd", 0, {27'b0, ifc[0].rsp_rd}, 32'd0);
    chk("rst_req_ready", 0, {31'b0, ifc[0].req_ready}, 32'd1);
    rst_n = 1'b1;

    // Directed vectors, STEP=4
    issue0(2'b00, 32'h0001_0000, 5'd5,  6'd15, 1'b1); wait_all(40);
    issue0(2'b01, 32'h0001_0000, 5'd6,  6'd16, 1'b1); wait_all(40);
    issue0(2'b01, 32'h0000_0000, 5'd7,  6'd32, 1'b1); wait_all(40);
    issue0(2'b00, 32'h8000_0000, 5'd8,  6'd0,  1'b1); wait_all(40);
    issue0(2'b10, 32'hF0F0_0001, 5'd10, 6'd9,  1'b1); wait_all(40);
    issue0(2'b10, 32'hFFFF_FFFF, 5'd31, 6'd32, 1'b1); wait_all(40);
    issue0(2'b11, 32'hFFFF_FFFF, 5'd1,  6'd0,  1'b1); wait_all(40);
    issue0(2'b00, 32'h0000_0000, 5'd2,  6'd32, 1'b1); wait_all(40);

    // Back-pressure in DONE
    ifc[0].rsp_ready = 1'b0;
    issue0(2'b00, 32'h0000_FFFF, 5'd9, 6'd16, 1'b1);
    n = 0;
    while (!ifc[0].rsp_valid && n < 40) begin @(negedge clk); n++; end
    chk("stall_valid_seen", 0, {31'b0, ifc[0].rsp_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_ready", 0, {31'b0, ifc[0].req_ready}, 32'd0);
      chk("stall_busy", 0, {31'b0, busy[0]}, 32'd1);
      @(negedge clk);
    end
    ifc[0].rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("post_hs_req_ready", 0, {31'b0, ifc[0].req_ready}, 32'd1);
    chk("post_hs_busy", 0, {31'b0, busy[0]}, 32'd0);
    chk("post_hs_valid", 0, {31'b0, ifc[0].rsp_valid}, 32'd0);
    wait_all(40);

    // Flush in RUN cycle 3: no response may ever appear
    issue0(2'b10, 32'hFFFF_FFFF, 5'd4, 6'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_busy", 0, {31'b0, busy[0]}, 32'd0);
    chk("flush_valid", 0, {31'b0, ifc[0].rsp_valid}, 32'd0);
    repeat (12) @(negedge clk);

    // Flush in IDLE blocks an accept
    flush = 1'b1;
    ifc[0].req_valid = 1'b1;
    ifc[0].req_op    = 2'b00;
    ifc[0].req_rs1   = 32'h1;
    #1;
    chk("flush_idle_ready", 0, {31'b0, ifc[0].req_ready}, 32'd0);
    @(negedge clk);
    chk("flush_idle_busy", 0, {31'b0, busy[0]}, 32'd0);
    flush = 1'b0;
    ifc[0].req_valid = 1'b0;
    repeat (12) @(negedge clk);

    // Reset during RUN discards the op and clears the response registers
    issue0(2'b00, 32'h0000_FFFF, 5'd11, 6'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_run_busy", 0, {31'b0, busy[0]}, 32'd0);
    chk("rst_run_valid", 0, {31'b0, ifc[0].rsp_valid}, 32'd0);
    chk("rst_run_data", 0, ifc[0].rsp_data, 32'd0);
    rst_n = 1'b1;
    issue0(2'b00, 32'h0000_0001, 5'd3, 6'd31, 1'b1);
    wait_all(40);

    // STEP sweep (1, 8, 32) against the reference model
    issue_sw(2'b00, 32'h0000_0000, 5'd1);  wait_all(80);
    issue_sw(2'b01, 32'h8000_0000, 5'd2);  wait_all(80);
    issue_sw(2'b10, 32'h1234_5678, 5'd3);  wait_all(80);
    issue_sw(2'b11, 32'hFFFF_FFFF, 5'd4);  wait_all(80);
    issue_sw(2'b10, 32'hFFFF_FFFF, 5'd5);  wait_all(80);
    for (int i = 0; i < 10; i++) begin
      issue_sw(2'($urandom_range(0, 2)), $urandom, 5'($urandom));
      wait_all(80);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
